// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
//
// Byte-wise copy engine for the minimal external-memory master interface.
// A start pulse latches a source base, a destination base and a byte count.
// The block then issues one read and one write per byte on the Mout_* bus,
// in ascending address order, and signals completion with a one-cycle
// done pulse. It is intended as a preload / relocation helper next to an
// HLS-generated core.
//
// Optional feature macro: MEM_COPY_TIMEOUT_EN
//   When defined, each outstanding request is guarded by a watchdog counter.
//   If TIMEOUT_CYCLES cycles pass without M_DataRdy, the request is dropped,
//   error_port is raised and the copy terminates through DONE. error_port
//   stays high until the next accepted start or reset. When undefined, there
//   is no counter, error_port is tied low and requests wait indefinitely.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   start_port         start pulse, only sampled while idle
//   src_addr           source base byte address
//   dst_addr           destination base byte address
//   length             number of bytes to copy (0 is legal)
//   done_port          one-cycle completion pulse
//   error_port         watchdog abort flag
//   Mout_oe_ram        read request
//   Mout_we_ram        write request
//   Mout_addr_ram      request byte address
//   Mout_Wdata_ram     write data
//   Mout_data_ram_size transfer size in bits (8 while requesting, else 0)
//   M_Rdata_ram        read data, valid in the M_DataRdy cycle of a read
//   M_DataRdy          request accepted / completed
// -----------------------------------------------------------------------------
module mem_copy_master #(
    parameter int BITSIZE_addr = 13,
    parameter int BITSIZE_data = 8,
    parameter int BITSIZE_size = 4
`ifdef MEM_COPY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_port,
    input  logic [BITSIZE_addr-1:0] src_addr,
    input  logic [BITSIZE_addr-1:0] dst_addr,
    input  logic [BITSIZE_addr-1:0] length,
    output logic                    done_port,
    output logic                    error_port,
    output logic                    Mout_oe_ram,
    output logic                    Mout_we_ram,
    output logic [BITSIZE_addr-1:0] Mout_addr_ram,
    output logic [BITSIZE_data-1:0] Mout_Wdata_ram,
    output logic [BITSIZE_size-1:0] Mout_data_ram_size,
    input  logic [BITSIZE_data-1:0] M_Rdata_ram,
    input  logic                    M_DataRdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [BITSIZE_addr-1:0] src_q;
    logic [BITSIZE_addr-1:0] dst_q;
    logic [BITSIZE_addr-1:0] len_q;
    logic [BITSIZE_addr-1:0] idx;
    logic [BITSIZE_addr-1:0] idx_next;
    logic [BITSIZE_data-1:0] buf_q;

    logic start_accept;
    logic timeout_hit;

    // A start is only honoured from IDLE; anything seen mid-copy is ignored.
    assign start_accept = (state == IDLE) && start_port;

    // Index of the following byte; natural wrap keeps the modulo arithmetic.
    assign idx_next = idx + BITSIZE_addr'(1);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero-length copy goes straight to DONE so the
    // completion pulse still appears one cycle after start. A watchdog
    // expiry (only possible when the timeout feature is built in) also
    // ends the copy through DONE so the caller always sees one pulse.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_port) begin
                    next_state = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (M_DataRdy) begin
                    next_state = WRITE;
                end else if (timeout_hit) begin
                    next_state = DONE;
                end
            end
            WRITE: begin
                if (M_DataRdy) begin
                    next_state = (idx_next == len_q) ? DONE : READ;
                end else if (timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Copy parameters and progress. The inputs are captured once at start
    // and never re-sampled, so the caller may change them during a copy.
    // The read byte is held in buf_q for the following write, which is what
    // makes overlapping forward copies replicate the source pattern.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx   <= '0;
            buf_q <= '0;
        end else begin
            if (start_accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= length;
                idx   <= '0;
            end
            if ((state == READ) && M_DataRdy) begin
                buf_q <= M_Rdata_ram;
            end
            if ((state == WRITE) && M_DataRdy) begin
                idx <= idx_next;
            end
        end
    end

    // Bus outputs are decoded purely from the state register and the
    // registered copy parameters, so M_DataRdy never reaches Mout_* within
    // the same cycle. Everything idles at zero outside READ/WRITE, which
    // also makes all outputs drop to zero as soon as reset is asserted.
    always_comb begin
        Mout_oe_ram        = 1'b0;
        Mout_we_ram        = 1'b0;
        Mout_addr_ram      = '0;
        Mout_Wdata_ram     = '0;
        Mout_data_ram_size = '0;
        done_port          = 1'b0;
        case (state)
            READ: begin
                Mout_oe_ram        = 1'b1;
                Mout_addr_ram      = src_q + idx;
                Mout_data_ram_size = BITSIZE_size'(8);
            end
            WRITE: begin
                Mout_we_ram        = 1'b1;
                Mout_addr_ram      = dst_q + idx;
                Mout_Wdata_ram     = buf_q;
                Mout_data_ram_size = BITSIZE_size'(8);
            end
            DONE: begin
                done_port = 1'b1;
            end
            default: begin
                done_port = 1'b0;
            end
        endcase
    end

`ifdef MEM_COPY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             request_active;
    logic             error_q;

    assign request_active = (state == READ) || (state == WRITE);

    // The counter holds the number of cycles the current request has
    // already waited, starting at 0 in its first cycle. Expiry is flagged
    // in the last allowed cycle so the request is visible for exactly
    // TIMEOUT_CYCLES cycles before being dropped.
    assign timeout_hit = request_active && !M_DataRdy &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and sticky error flag. The counter clears whenever a
    // request completes, so every new request starts its own budget. The
    // error flag survives the DONE pulse and is cleared by the next start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (request_active && !M_DataRdy) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (start_accept) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_port = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error_port  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_master
//
// Bench for mem_copy_master. A byte-wide memory model with configurable
// read/write acceptance delay answers the DUT. Expected read addresses and
// write (address, data) pairs are computed from a shadow copy of memory when
// each copy is started and are popped as the DUT's requests are accepted.
// Table-driven vectors cover the main copy cases; hand-written sequences cover
// reset mid-copy and, with MEM_COPY_TIMEOUT_EN, the watchdog abort.
// -----------------------------------------------------------------------------
module tb_mem_copy_master;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start_port = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] length = '0;
    logic          done_port;
    logic          error_port;
    logic          Mout_oe_ram;
    logic          Mout_we_ram;
    logic [AW-1:0] Mout_addr_ram;
    logic [DW-1:0] Mout_Wdata_ram;
    logic [SW-1:0] Mout_data_ram_size;
    logic [DW-1:0] M_Rdata_ram;
    logic          M_DataRdy;

`ifdef MEM_COPY_TIMEOUT_EN
    mem_copy_master #(
        .BITSIZE_addr(AW),
        .BITSIZE_data(DW),
        .BITSIZE_size(SW),
        .TIMEOUT_CYCLES(8)
    ) dut (
`else
    mem_copy_master #(
        .BITSIZE_addr(AW),
        .BITSIZE_data(DW),
        .BITSIZE_size(SW)
    ) dut (
`endif
        .clock(clock),
        .reset(reset),
        .start_port(start_port),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length(length),
        .done_port(done_port),
        .error_port(error_port),
        .Mout_oe_ram(Mout_oe_ram),
        .Mout_we_ram(Mout_we_ram),
        .Mout_addr_ram(Mout_addr_ram),
        .Mout_Wdata_ram(Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram),
        .M_DataRdy(M_DataRdy)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Memory model: a request is accepted in its delay-th cycle.
    // ------------------------------------------------------------------
    logic [7:0] mem    [0:8191];
    logic [7:0] shadow [0:8191];
    int         rd_delay = 1;
    int         wr_delay = 1;
    bit         never_rdy = 1'b0;
    bit         load_mem = 1'b0;
    int         req_cnt = 0;
    logic       req_active;

    assign req_active  = Mout_oe_ram | Mout_we_ram;
    assign M_DataRdy   = req_active && !never_rdy &&
                         (req_cnt == ((Mout_oe_ram ? rd_delay : wr_delay) - 1));
    assign M_Rdata_ram = Mout_oe_ram ? mem[Mout_addr_ram] : 8'h00;

    // The memory array is only ever written here, both for the initial
    // pattern load and for DUT writes.
    always @(posedge clock) begin
        if (req_active && !M_DataRdy) begin
            req_cnt <= req_cnt + 1;
        end else begin
            req_cnt <= 0;
        end
        if (load_mem) begin
            for (int i = 0; i < 8192; i++) begin
                mem[i] <= 8'(i * 7 + 3);
            end
            mem[13'h010] <= 8'hA1;
            mem[13'h011] <= 8'hA2;
            mem[13'h012] <= 8'hA3;
            mem[13'h013] <= 8'hA4;
            mem[13'h020] <= 8'h5A;
        end else if (Mout_we_ram && M_DataRdy) begin
            mem[Mout_addr_ram] <= Mout_Wdata_ram;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [AW-1:0] exp_rd_q [$];
    wr_t           exp_wr_q [$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int req_cycles = 0;
    int proto_err = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Observes the bus mid-cycle, pops the scoreboard on accepted requests
    // and tallies protocol violations.
    always @(negedge clock) begin
        if (Mout_oe_ram && Mout_we_ram) proto_err++;
        if (req_active != (Mout_data_ram_size == 4'd8)) proto_err++;
        if (!req_active && (Mout_addr_ram != '0 || Mout_Wdata_ram != '0)) proto_err++;
        if (req_active) req_cycles++;
        if (done_port) done_cnt++;
        if (Mout_oe_ram && M_DataRdy) begin
            if (exp_rd_q.size() == 0) begin
                check_output("rd_unexpected", int'(Mout_addr_ram), -1);
            end else begin
                check_output("rd_addr", int'(Mout_addr_ram), int'(exp_rd_q.pop_front()));
            end
        end
        if (Mout_we_ram && M_DataRdy) begin
            if (exp_wr_q.size() == 0) begin
                check_output("wr_unexpected", int'(Mout_addr_ram), -1);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check_output("wr_addr", int'(Mout_addr_ram), int'(e.addr));
                check_output("wr_data", int'(Mout_Wdata_ram), int'(e.data));
            end
        end
    end

    // Ascending byte copy on the shadow image; overlap replication and
    // address wrap fall out of doing it one byte at a time.
    task automatic load_expect(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                               input logic [AW-1:0] len);
        for (int i = 0; i < 8192; i++) shadow[i] = mem[i];
        for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            wr_t           e;
            ra = src + AW'(i);
            wa = dst + AW'(i);
            exp_rd_q.push_back(ra);
            e.addr = wa;
            e.data = shadow[ra];
            exp_wr_q.push_back(e);
            shadow[wa] = shadow[ra];
        end
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] len;
        int            rd;
        int            wr;
        int            exp_done;
        bit            hold;
    } vec_t;

    // Runs one complete copy and checks its timing and bookkeeping. With
    // hold set, start stays high for three cycles with scrambled inputs,
    // which the DUT must ignore once it has left IDLE.
    task automatic apply_stimulus(input vec_t v);
        int cyc;
        int first_done;
        rd_delay = v.rd;
        wr_delay = v.wr;
        load_expect(v.src, v.dst, v.len);
        @(negedge clock);
        done_cnt   = 0;
        req_cycles = 0;
        src_addr   = v.src;
        dst_addr   = v.dst;
        length     = v.len;
        start_port = 1'b1;
        cyc        = 0;
        first_done = -1;
        while (cyc < v.exp_done + 3) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1 && v.hold) begin
                src_addr = ~v.src;
                dst_addr = ~v.dst;
                length   = v.len + 13'd1;
            end
            if (cyc >= (v.hold ? 3 : 1)) start_port = 1'b0;
            if (done_port && first_done < 0) first_done = cyc;
        end
        #1;
        check_output("done_cycle", first_done, v.exp_done);
        check_output("done_pulses", done_cnt, 1);
        check_output("req_cycles", req_cycles, int'(v.len) * (v.rd + v.wr));
        check_output("rd_left", exp_rd_q.size(), 0);
        check_output("wr_left", exp_wr_q.size(), 0);
        check_output("protocol", proto_err, 0);
        check_output("error_port", int'(error_port), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [6];
        vec_t fresh;
        int   cyc;
        int   last_oe;
        int   done_at;
        int   err9;
        int   err11;

        vecs[0] = '{13'h0010, 13'h0100, 13'd4, 2, 1, 13, 1'b0};
        vecs[1] = '{13'h0055, 13'h0066, 13'd0, 2, 1, 1, 1'b0};
        vecs[2] = '{13'h1FFE, 13'h0004, 13'd4, 1, 1, 9, 1'b0};
        vecs[3] = '{13'h0020, 13'h0021, 13'd3, 1, 2, 10, 1'b0};
        vecs[4] = '{13'h0300, 13'h0400, 13'd5, 3, 3, 31, 1'b1};
        vecs[5] = '{13'h0123, 13'h1FFF, 13'd2, 1, 1, 5, 1'b0};

        load_mem = 1'b1;
        @(negedge clock);
        @(negedge clock);
        load_mem = 1'b0;
        #1;
        check_output("rst_done", int'(done_port), 0);
        check_output("rst_error", int'(error_port), 0);
        check_output("rst_oe", int'(Mout_oe_ram), 0);
        check_output("rst_we", int'(Mout_we_ram), 0);
        check_output("rst_addr", int'(Mout_addr_ram), 0);
        check_output("rst_size", int'(Mout_data_ram_size), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d src=%h dst=%h len=%0d", i, vecs[i].src, vecs[i].dst, vecs[i].len);
            apply_stimulus(vecs[i]);
        end

        check_output("copy_100", int'(mem[13'h100]), 8'hA1);
        check_output("copy_101", int'(mem[13'h101]), 8'hA2);
        check_output("copy_102", int'(mem[13'h102]), 8'hA3);
        check_output("copy_103", int'(mem[13'h103]), 8'hA4);
        check_output("overlap_21", int'(mem[13'h021]), 8'h5A);
        check_output("overlap_23", int'(mem[13'h023]), 8'h5A);

        // Reset asserted in the middle of the second write.
        $display("[TB] reset during second write");
        rd_delay = 2;
        wr_delay = 1;
        load_expect(13'h0600, 13'h0700, 13'd4);
        @(negedge clock);
        src_addr   = 13'h0600;
        dst_addr   = 13'h0700;
        length     = 13'd4;
        start_port = 1'b1;
        cyc = 0;
        while (cyc < 6) begin
            @(negedge clock);
            cyc++;
            start_port = 1'b0;
        end
        #2;
        check_output("mid_we", int'(Mout_we_ram), 1);
        check_output("mid_addr", int'(Mout_addr_ram), 13'h0701);
        reset = 1'b0;
        #1;
        check_output("arst_we", int'(Mout_we_ram), 0);
        check_output("arst_oe", int'(Mout_oe_ram), 0);
        check_output("arst_addr", int'(Mout_addr_ram), 0);
        check_output("arst_wdata", int'(Mout_Wdata_ram), 0);
        check_output("arst_size", int'(Mout_data_ram_size), 0);
        check_output("arst_done", int'(done_port), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        done_cnt = 0;
        repeat (3) @(negedge clock);
        #1;
        check_output("arst_no_done", done_cnt, 0);
        reset = 1'b1;
        @(negedge clock);
        fresh = '{13'h0600, 13'h0780, 13'd4, 2, 1, 13, 1'b0};
        apply_stimulus(fresh);

`ifdef MEM_COPY_TIMEOUT_EN
        // Memory never answers: the read must be dropped after 8 cycles.
        $display("[TB] timeout abort");
        never_rdy = 1'b1;
        @(negedge clock);
        src_addr   = 13'h0800;
        dst_addr   = 13'h0900;
        length     = 13'd2;
        start_port = 1'b1;
        cyc = 0;
        last_oe = -1;
        done_at = -1;
        err9 = -1;
        err11 = -1;
        while (cyc < 12) begin
            @(negedge clock);
            cyc++;
            start_port = 1'b0;
            if (Mout_oe_ram) last_oe = cyc;
            if (done_port && done_at < 0) done_at = cyc;
            if (cyc == 9) err9 = int'(error_port);
            if (cyc == 11) err11 = int'(error_port);
        end
        check_output("to_last_oe", last_oe, 8);
        check_output("to_done", done_at, 9);
        check_output("to_err_done", err9, 1);
        check_output("to_err_sticky", err11, 1);
        never_rdy = 1'b0;
        fresh = '{13'h0A00, 13'h0B00, 13'd3, 1, 1, 7, 1'b0};
        apply_stimulus(fresh);
`else
        cyc = 0;
        last_oe = 0;
        done_at = 0;
        err9 = 0;
        err11 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Synthesizable initiator for the HLS minimal external-memory interface: on a `start_port` pulse it copies `length` bytes from `src_addr` to `dst_addr`, one byte at a time, by issuing read then write requests on the `Mout_*` bus. It drives the interface from the master side and is accepted by the memory models the simulation benches provide. It sits beside the HLS `main` core as a preload/relocation engine. It finishes with a one-cycle `done_port` pulse.

## Interface
- `BITSIZE_addr`, 13, width of byte addresses and of `length`
- `BITSIZE_data`, 8, data bus width (fixed at one byte per transfer)
- `BITSIZE_size`, 4, width of `Mout_data_ram_size`
- `TIMEOUT_CYCLES`, 1024, watchdog limit per request (only with `MEM_COPY_TIMEOUT_EN`)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start_port`  in  1  start pulse, sampled only in IDLE
- `src_addr`  in  BITSIZE_addr  source base byte address
- `dst_addr`  in  BITSIZE_addr  destination base byte address
- `length`  in  BITSIZE_addr  byte count; 0 is legal
- `done_port`  out  1  one-cycle completion pulse
- `error_port`  out  1  timeout abort flag (constant 0 without the macro)
- `Mout_oe_ram`  out  1  read request
- `Mout_we_ram`  out  1  write request
- `Mout_addr_ram`  out  BITSIZE_addr  request byte address
- `Mout_Wdata_ram`  out  BITSIZE_data  write data
- `Mout_data_ram_size`  out  BITSIZE_size  transfer size in bits; 8 while a request is active, else 0
- `M_Rdata_ram`  in  BITSIZE_data  read data, valid in the `M_DataRdy` cycle of a read
- `M_DataRdy`  in  1  request accepted/completed

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: `src_q`, `dst_q`, `len_q`, byte index `idx`, data buffer `buf_q`.
- IDLE: with `start_port`=1, latch src/dst/length and clear `idx`. If length=0, go to DONE. Otherwise go to READ.
- READ: drive `Mout_oe_ram`=1 and `Mout_addr_ram`=`src_q+idx`. Hold both until `M_DataRdy`=1. Then latch `buf_q`=`M_Rdata_ram` and go to WRITE.
- WRITE: drive `Mout_we_ram`=1, `Mout_addr_ram`=`dst_q+idx` and `Mout_Wdata_ram`=`buf_q`. Hold until `M_DataRdy`=1. Then `idx`+1; if the new `idx`==`len_q`, go to DONE, else go to READ.
- DONE: `done_port`=1 for exactly one cycle, then IDLE.
- `Mout_oe_ram` and `Mout_we_ram` are never high in the same cycle. Both are 0 in IDLE and DONE.
- Address sums wrap modulo 2^BITSIZE_addr.
- Copy order is ascending. If the regions overlap with `dst` > `src`, the source pattern is replicated; this is defined behaviour, not an error.
- `start_port` outside IDLE is ignored. Inputs are not re-sampled mid-copy.
- `M_DataRdy` in IDLE or DONE is ignored.
- `reset`=0 at any time: state to IDLE and every output to 0 (`Mout_addr_ram`, `Mout_Wdata_ram`, `Mout_data_ram_size` included). An in-flight request is dropped with no done pulse.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from `M_DataRdy` to `Mout_*` within a cycle.
- Cycle 0 = the `start_port` cycle. The first read is asserted in cycle 1.
- A request asserted in cycle t and accepted with `M_DataRdy` in cycle t+d-1 (d ≥ 1) is followed by the next request in cycle t+d.
- With read delay R and write delay W, `done_port` is high in cycle `length*(R+W)+1`. For `length`=0, `done_port` is high in cycle 1.
- A new `start_port` is accepted in the cycle after `done_port`.

## Configuration
- `MEM_COPY_TIMEOUT_EN` defined:
  - A per-request counter runs in READ/WRITE and resets on each new request.
  - If it reaches `TIMEOUT_CYCLES` without `M_DataRdy`, the request is dropped, `error_port` is set, and the block goes to DONE.
  - `error_port` stays high until the next accepted start or reset.
- Not defined: no counter; `error_port` is tied to 0; the block waits indefinitely for `M_DataRdy`.

## Test plan
- Memory model R=2, W=1; src=0x010, dst=0x100, length=4, source bytes A1 A2 A3 A4 → dst holds A1..A4, `done_port` high in cycle 13, exactly one pulse.
- length=0 → no `oe`/`we` ever asserted; `done_port` high in cycle 1.
- src=0x1FFE, dst=0x0004, length=4 → reads at 1FFE, 1FFF, 0000, 0001 (wrap); writes at 0004..0007.
- Overlap: src=0x20, dst=0x21, length=3, mem[0x20]=5A → 0x21..0x23 = 5A.
- `reset` low during the second WRITE → all outputs 0 in the same cycle, state IDLE, no `done_port`; a fresh start then completes normally.
- Macro on, `TIMEOUT_CYCLES`=8, `M_DataRdy` held 0 → `oe` dropped after 8 cycles, `error_port`=1, one `done_port` pulse.
